// File: rtl/div_pkg.sv
// Shared types for the sequential radix-2 divider.
// The divider walks these states in order, with early exits from PREP to DONE.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic           borrow;

  // Quotient bit is 1 when the trial subtraction does not borrow.
  always_comb begin
    shifted = {rem_in, q_in[WIDTH-1]};
    borrow  = (shifted < divisor);
    if (borrow) begin
      rem_out = shifted[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = WIDTH'(shifted - divisor);
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider_rv.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready on both sides.
// One operation in flight; the result is held in DONE until the consumer takes it.
module seq_divider_rv
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;
  } div_result_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic             is_signed_q, is_signed_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   abs_dvs_q, abs_dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  div_result_t      res_q, res_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   dvd_ext;
  logic [WIDTH:0]   dvs_ext;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_in    (quo_q),
    .divisor (abs_dvs_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // Next-state, datapath and result logic; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    is_signed_d = is_signed_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    abs_dvs_d   = abs_dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    cnt_d       = cnt_q;
    res_d       = res_q;

    dvd_neg = is_signed_q & dvd_q[WIDTH-1];
    dvs_neg = is_signed_q & dvs_q[WIDTH-1];
    dvd_ext = {dvd_neg, dvd_q};
    dvs_ext = {dvs_neg, dvs_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          is_signed_d = is_signed;
          dvd_d       = dividend;
          dvs_d       = divisor;
          state_d     = PREP;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        if (dvs_q == {WIDTH{1'b0}}) begin
          res_d.quotient  = {WIDTH{1'b1}};
          res_d.remainder = dvd_q;
          res_d.div_zero  = 1'b1;
          res_d.overflow  = 1'b0;
          state_d         = DONE;
        end else if (is_signed_q && (dvd_q == MIN_VAL) && (dvs_q == {WIDTH{1'b1}})) begin
          res_d.quotient  = MIN_VAL;
          res_d.remainder = {WIDTH{1'b0}};
          res_d.div_zero  = 1'b0;
          res_d.overflow  = 1'b1;
          state_d         = DONE;
        end else begin
          // Magnitudes are taken on WIDTH+1 bits so |MIN| does not wrap.
          rem_d     = {WIDTH{1'b0}};
          quo_d     = WIDTH'(dvd_neg ? ((~dvd_ext) + (WIDTH+1)'(1)) : dvd_ext);
          abs_dvs_d = dvs_neg ? ((~dvs_ext) + (WIDTH+1)'(1)) : dvs_ext;
          q_neg_d   = dvd_neg ^ dvs_neg;
          r_neg_d   = dvd_neg;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end
      FIX: begin
        res_d.quotient  = q_neg_q ? ((~quo_q) + WIDTH'(1)) : quo_q;
        res_d.remainder = r_neg_q ? ((~rem_q) + WIDTH'(1)) : rem_q;
        res_d.div_zero  = 1'b0;
        res_d.overflow  = 1'b0;
        state_d         = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      res_d   = '0;
    end else begin
      state_d = state_d;
    end
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      is_signed_q <= 1'b0;
      dvd_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      abs_dvs_q   <= {(WIDTH+1){1'b0}};
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_signed_q <= is_signed_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      abs_dvs_q   <= abs_dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = res_q.quotient;
  assign remainder = res_q.remainder;
  assign div_zero  = res_q.div_zero;
  assign overflow  = res_q.overflow;

endmodule

// File: tb/tb_seq_divider_rv.sv
// Scoreboard bench for seq_divider_rv (WIDTH=8): stimulus pushes expectations, a monitor pops on handoff.
module tb_seq_divider_rv;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic       is_signed;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;
  logic       overflow;

  seq_divider_rv #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares whatever the DUT hands off against the head of the scoreboard.
  initial begin : monitor
    int unsigned first_v;
    logic        prev_v;
    exp_t        e;
    first_v = 0;
    prev_v  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && !prev_v) first_v = cyc;
      prev_v = reset_n && out_valid;
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient", {24'd0, quotient}, {24'd0, e.q});
          check("remainder", {24'd0, remainder}, {24'd0, e.r});
          check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
          check("overflow", {31'd0, overflow}, {31'd0, e.ov});
          check("latency", first_v - e.acc, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic sgn, input logic [7:0] a, input logic [7:0] b, input bit push,
                       input logic [7:0] q, input logic [7:0] r, input logic dz, input logic ov,
                       input int unsigned lat);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid  = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    is_signed = ~sgn;
    dividend  = 8'hAA;
    divisor   = 8'h55;
    if (push) begin
      e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    dividend  = 8'h00;
    divisor   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b1;
    #22;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    issue(1'b0, 8'd100, 8'd7,   1'b1, 8'h0E, 8'h02, 1'b0, 1'b0, 32'd10); drain();
    issue(1'b1, 8'h9C,  8'h07,  1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 32'd10); drain();
    issue(1'b1, 8'd100, 8'hF9,  1'b1, 8'hF2, 8'h02, 1'b0, 1'b0, 32'd10); drain();
    issue(1'b0, 8'd5,   8'h00,  1'b1, 8'hFF, 8'h05, 1'b1, 1'b0, 32'd1);  drain();
    issue(1'b1, 8'd5,   8'h00,  1'b1, 8'hFF, 8'h05, 1'b1, 1'b0, 32'd1);  drain();
    issue(1'b1, 8'h80,  8'hFF,  1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 32'd1);  drain();
    issue(1'b0, 8'h80,  8'hFF,  1'b1, 8'h00, 8'h80, 1'b0, 1'b0, 32'd10); drain();
    issue(1'b0, 8'h00,  8'h03,  1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 32'd10); drain();
    // -128 / 3 = -42 rem -2 exercises the exact |MIN| magnitude.
    issue(1'b1, 8'h80,  8'h03,  1'b1, 8'hD6, 8'hFE, 1'b0, 1'b0, 32'd10); drain();

    // Backpressure: hold the result in DONE while a new request waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(1'b0, 8'd200, 8'd9, 1'b1, 8'h16, 8'h02, 1'b0, 1'b0, 32'd10);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    in_valid  = 1'b1;
    dividend  = 8'd50;
    divisor   = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_quotient", {24'd0, quotient}, 32'h16);
      check("bp_remainder", {24'd0, remainder}, 32'h02);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("bp_after_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_after_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush during ITER, with a competing request in the same cycle.
    issue(1'b0, 8'd200, 8'd9, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("flush_no_accept", {31'd0, in_ready}, 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    check("flush_still_idle", {31'd0, out_valid}, 32'd0);
    issue(1'b0, 8'd200, 8'd9, 1'b1, 8'h16, 8'h02, 1'b0, 1'b0, 32'd10); drain();

    // Asynchronous reset pulse mid-operation.
    issue(1'b1, 8'h9C, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_quotient", {24'd0, quotient}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("arst_still_idle", {31'd0, out_valid}, 32'd0);
    issue(1'b0, 8'd200, 8'd9, 1'b1, 8'h16, 8'h02, 1'b0, 1'b0, 32'd10); drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
